// File: rtl/oled_spi_receiver_if.sv
// Display-link bundle between an SPI master / byte consumer and the OLED receiver model.
interface oled_spi_receiver_if;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       oled_dc;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_valid;
    logic       rx_ready;
    logic       overflow;
    logic       overflow_clr;
    logic       frame_err;
    logic       display_on;

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n, oled_dc, rx_ready, overflow_clr,
        input  rx_data, rx_dc, rx_valid, overflow, frame_err, display_on
    );

    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n, oled_dc, rx_ready, overflow_clr,
        output rx_data, rx_dc, rx_valid, overflow, frame_err, display_on
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// SPI mode-0 slave modelling the OLED panel: oversampled byte capture, show-ahead FIFO
// and display on/off command decode.
module oled_spi_receiver #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic        DC_CMD_LEVEL    = 1'b1,
    parameter logic [7:0]  CMD_DISPLAY_OFF = 8'hAE,
    parameter logic [7:0]  CMD_DISPLAY_ON  = 8'hAF
) (
    input  logic                clk,
    input  logic                reset,
    oled_spi_receiver_if.slave  bus_io
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    // Input vector order {sclk, mosi, dc, cs_n}; idle levels below.
    localparam logic [3:0]  InIdle = 4'b0001;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    logic [3:0]      sync1_q, sync2_q, algn_q;
    logic            sclk_prev_q;
    state_e          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic            display_q, display_d;
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    logic       sclk_s, mosi_s, dc_s, cs_s, rise;
    logic       byte_done, push, pop, full, wr_en;
    logic [7:0] byte_val;

    // Two-flop synchronizer plus one alignment stage shared by all four inputs so they
    // keep equal delay; edge detection works on the aligned copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= InIdle;
            sync2_q     <= InIdle;
            algn_q      <= InIdle;
            sclk_prev_q <= 1'b0;
        end else begin
            sync1_q     <= {bus_io.spi_sclk, bus_io.spi_mosi, bus_io.oled_dc, bus_io.spi_cs_n};
            sync2_q     <= sync1_q;
            algn_q      <= sync2_q;
            sclk_prev_q <= algn_q[3];
        end
    end

    assign sclk_s   = algn_q[3];
    assign mosi_s   = algn_q[2];
    assign dc_s     = algn_q[1];
    assign cs_s     = algn_q[0];
    assign rise     = sclk_s & ~sclk_prev_q;
    assign byte_val = {shift_q[6:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = 3'd0;
                if (!cs_s) state_d = StShift;
            end
            StShift: begin
                if (cs_s) begin
                    state_d     = StIdle;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                    shift_d     = 8'h00;
                end else if (rise) begin
                    shift_d = byte_val;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        byte_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push  = byte_done;
    assign pop   = (count_q != '0) && bus_io.rx_ready;
    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + CntW'(1);
        else if (!wr_en && pop) count_d = count_q - CntW'(1);

        overflow_d = overflow_q;
        if (push && full && !pop)     overflow_d = 1'b1;
        else if (bus_io.overflow_clr) overflow_d = 1'b0;

        // Decode regardless of whether the FIFO accepted the byte.
        display_d = display_q;
        if (byte_done && (dc_s == DC_CMD_LEVEL)) begin
            if (byte_val == CMD_DISPLAY_ON)       display_d = 1'b1;
            else if (byte_val == CMD_DISPLAY_OFF) display_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            display_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            display_q   <= display_d;
            count_q     <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {dc_s, byte_val};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    assign bus_io.rx_data    = mem_q[rd_ptr_q][7:0];
    assign bus_io.rx_dc      = mem_q[rd_ptr_q][8];
    assign bus_io.rx_valid   = (count_q != '0);
    assign bus_io.overflow   = overflow_q;
    assign bus_io.frame_err  = frame_err_q;
    assign bus_io.display_on = display_q;
endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: SPI bytes at 4 clk per phase, hand-computed results.
module tb_oled_spi_receiver;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   fe_count;

    oled_spi_receiver_if bus ();

    oled_spi_receiver #(
        .FIFO_DEPTH      (4),
        .DC_CMD_LEVEL    (1'b1),
        .CMD_DISPLAY_OFF (8'hAE),
        .CMD_DISPLAY_ON  (8'hAF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.frame_err === 1'b1) fe_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_set(input logic v);
        @(negedge clk);
        bus.spi_cs_n = v;
        idle(4);
    endtask

    // mode 0: plain; 1: pulse rx_ready on the push edge; 2: check push latency (empty FIFO)
    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits,
                             input int mode);
        bus.oled_dc = dc;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.spi_sclk = 1'b0;
            bus.spi_mosi = b[7-i];
            idle(4);
            bus.spi_sclk = 1'b1;
            if (i == 7 && mode != 0) begin
                idle(3);
                if (mode == 1) bus.rx_ready = 1'b1;
                if (mode == 2) check("latency_before", {31'd0, bus.rx_valid}, 32'd0);
                idle(1);
                if (mode == 1) bus.rx_ready = 1'b0;
                if (mode == 2) check("latency_at", {31'd0, bus.rx_valid}, 32'd1);
            end else begin
                idle(4);
            end
        end
        bus.spi_sclk = 1'b0;
        idle(5);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic dc);
        check({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, bus.rx_data}, {24'd0, d});
        check({tag, "_dc"}, {31'd0, bus.rx_dc}, {31'd0, dc});
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fe_count = 0;
        reset = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.oled_dc = 1'b0;
        bus.rx_ready = 1'b0;
        bus.overflow_clr = 1'b0;
        idle(3);
        check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        check("rst_disp", {31'd0, bus.display_on}, 32'd0);
        reset = 1'b0;
        idle(4);

        // Single command byte
        cs_set(1'b0);
        send_bits(8'hAF, 1'b1, 8, 2);
        cs_set(1'b1);
        check("cmd_disp_on", {31'd0, bus.display_on}, 32'd1);
        pop_check("cmd", 8'hAF, 1'b1);
        check("cmd_empty", {31'd0, bus.rx_valid}, 32'd0);
        check("cmd_no_fe", fe_count, 32'd0);

        // Mixed stream with back-pressure
        cs_set(1'b0);
        send_bits(8'hAE, 1'b1, 8, 0);
        send_bits(8'h55, 1'b0, 8, 0);
        send_bits(8'hAA, 1'b0, 8, 0);
        cs_set(1'b1);
        check("mix_disp_off", {31'd0, bus.display_on}, 32'd0);
        pop_check("mix0", 8'hAE, 1'b1);
        pop_check("mix1", 8'h55, 1'b0);
        pop_check("mix2", 8'hAA, 1'b0);
        check("mix_empty", {31'd0, bus.rx_valid}, 32'd0);

        // Overflow
        cs_set(1'b0);
        for (int k = 1; k <= 6; k++) send_bits(8'(k), 1'b0, 8, 0);
        cs_set(1'b1);
        check("ovf_set", {31'd0, bus.overflow}, 32'd1);
        @(negedge clk);
        bus.overflow_clr = 1'b1;
        @(negedge clk);
        bus.overflow_clr = 1'b0;
        check("ovf_clr", {31'd0, bus.overflow}, 32'd0);
        for (int k = 1; k <= 4; k++) pop_check("ovf_pop", 8'(k), 1'b0);
        check("ovf_empty", {31'd0, bus.rx_valid}, 32'd0);

        // Full FIFO, push coincides with pop
        cs_set(1'b0);
        for (int k = 1; k <= 4; k++) send_bits(8'(k), 1'b0, 8, 0);
        send_bits(8'h05, 1'b0, 8, 1);
        cs_set(1'b1);
        check("fpp_no_ovf", {31'd0, bus.overflow}, 32'd0);
        for (int k = 2; k <= 5; k++) pop_check("fpp_pop", 8'(k), 1'b0);
        check("fpp_empty", {31'd0, bus.rx_valid}, 32'd0);

        // Framing error after 5 bits of AF
        cs_set(1'b0);
        send_bits(8'hAF, 1'b1, 5, 0);
        cs_set(1'b1);
        idle(4);
        check("fe_pulse_cycles", fe_count, 32'd1);
        check("fe_no_entry", {31'd0, bus.rx_valid}, 32'd0);
        check("fe_disp", {31'd0, bus.display_on}, 32'd0);
        cs_set(1'b0);
        send_bits(8'h5A, 1'b0, 8, 0);
        cs_set(1'b1);
        pop_check("fe_next", 8'h5A, 1'b0);

        // Reset mid-byte
        cs_set(1'b0);
        send_bits(8'hAF, 1'b1, 8, 0);
        check("pre_rst_disp", {31'd0, bus.display_on}, 32'd1);
        send_bits(8'hFF, 1'b1, 3, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
        check("mid_rst_dc", {31'd0, bus.rx_dc}, 32'd0);
        check("mid_rst_disp", {31'd0, bus.display_on}, 32'd0);
        check("mid_rst_fe", {31'd0, bus.frame_err}, 32'd0);
        idle(3);
        reset = 1'b0;
        idle(5);
        send_bits(8'h3C, 1'b0, 8, 0);
        cs_set(1'b1);
        pop_check("post_rst", 8'h3C, 1'b0);
        check("post_rst_empty", {31'd0, bus.rx_valid}, 32'd0);
        check("post_rst_disp", {31'd0, bus.display_on}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
